// File: rtl/branch_condition_unit.sv
// -----------------------------------------------------------------------------
// branch_condition_unit
//
// Consumer side of the processor status flags. Evaluates 4-bit branch
// condition codes against the live N/Z/C/V/M flags behind a valid/ready
// handshake with one registered result stage. Optionally keeps a LIFO of saved
// flag contexts so software-interrupt entry/return can snapshot and restore
// the flags.
//
// Configuration macro:
//   BCU_CTX_STACK_EN  defined     -> flag-context LIFO, push/pop, restore and
//                                    stack status outputs are active.
//                     not defined -> no LIFO; push/pop/clear_error ignored,
//                                    restore/stack outputs tied to idle values.
//
// Parameters:
//   DEPTH          number of flag-context entries in the LIFO (2..16)
//
// Ports:
//   clock          single clock, rising edge
//   reset          asynchronous, active-low reset
//   negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag
//                  live status flags from the status register
//   req_valid      condition request present
//   req_cond[3:0]  condition code
//   req_ready      request accepted when req_valid & req_ready
//   res_valid      result held in the output stage
//   res_taken      condition outcome
//   res_ready      downstream consumes the held result
//   push           save the current five flags onto the LIFO
//   pop            restore the top LIFO entry
//   restore_valid  one-cycle pulse, restored flags on restore_flags
//   restore_flags  restored {N,Z,C,V,M}, holds between pops
//   stack_empty    LIFO holds no entries
//   stack_full     LIFO holds DEPTH entries
//   stack_error    sticky overflow/underflow indication
//   clear_error    synchronous clear of stack_error (a new error wins)
// -----------------------------------------------------------------------------
module branch_condition_unit #(
   parameter int DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       negative_flag,
   input  logic       zero_flag,
   input  logic       carry_flag,
   input  logic       overflow_flag,
   input  logic       mode_flag,
   input  logic       req_valid,
   input  logic [3:0] req_cond,
   output logic       req_ready,
   output logic       res_valid,
   output logic       res_taken,
   input  logic       res_ready,
   input  logic       push,
   input  logic       pop,
   output logic       restore_valid,
   output logic [4:0] restore_flags,
   output logic       stack_empty,
   output logic       stack_full,
   output logic       stack_error,
   input  logic       clear_error
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Flags packed as {N,Z,C,V,M}, the same layout as restore_flags.
   logic [4:0] live_flags;
   assign live_flags = {negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag};

   function automatic logic eval_cond(input logic [3:0] cond, input logic [4:0] f);
      logic n, z, c, v, m;
      logic taken;
      n = f[4];
      z = f[3];
      c = f[2];
      v = f[1];
      m = f[0];
      case (cond)
         4'd0:    taken = z;
         4'd1:    taken = !z;
         4'd2:    taken = c;
         4'd3:    taken = !c;
         4'd4:    taken = n;
         4'd5:    taken = !n;
         4'd6:    taken = v;
         4'd7:    taken = !v;
         4'd8:    taken = c & !z;
         4'd9:    taken = !c | z;
         4'd10:   taken = (n == v);
         4'd11:   taken = (n != v);
         4'd12:   taken = !z & (n == v);
         4'd13:   taken = z | (n != v);
         4'd14:   taken = 1'b1;
         default: taken = m;          // SV: only in mode 1
      endcase
      return taken;
   endfunction

   // ---------------------------------------------------------------------------
   // Result stage
   // ---------------------------------------------------------------------------
   state_t state_reg, state_next;
   logic   res_taken_reg, res_taken_next;
   logic   accept;
   logic   cond_taken;

   assign res_valid  = (state_reg == ST_FULL);
   assign req_ready  = !res_valid | res_ready;
   assign accept     = req_valid & req_ready;
   // Flags are sampled in the acceptance cycle; later flag changes do not
   // disturb a held result.
   assign cond_taken = eval_cond(req_cond, live_flags);
   assign res_taken  = res_taken_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_EMPTY;
         res_taken_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         res_taken_reg <= res_taken_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      res_taken_next = res_taken_reg;
      case (state_reg)
         ST_EMPTY: begin
            if (accept) begin
               state_next     = ST_FULL;
               res_taken_next = cond_taken;
            end
         end
         ST_FULL: begin
            // In FULL an accept implies res_ready, so this is the
            // back-to-back replace case.
            if (accept) begin
               res_taken_next = cond_taken;
            end else if (res_ready) begin
               state_next = ST_EMPTY;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

`ifdef BCU_CTX_STACK_EN
   // ---------------------------------------------------------------------------
   // Flag-context LIFO
   // ---------------------------------------------------------------------------
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [4:0]    ctx_mem [DEPTH];
   logic [CW-1:0] count_reg, count_next;
   logic          restore_valid_reg;
   logic [4:0]    restore_flags_reg, restore_flags_next;
   logic          error_reg, error_next;
   logic          empty, full;
   logic          do_push, do_pop, err_set;
   logic [AW-1:0] top_idx, wr_idx;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign top_idx = AW'(count_reg - CW'(1));

   // A pop on an empty stack is ignored; a push on a full stack only proceeds
   // when a simultaneous pop frees the top slot.
   assign do_pop  = pop & !empty;
   assign do_push = push & (!full | do_pop);
   assign err_set = (pop & empty) | (push & full & !pop);

   // Push+pop overwrites the slot just read, leaving count unchanged.
   assign wr_idx  = do_pop ? top_idx : count_reg[AW-1:0];

   always_comb begin
      count_next         = count_reg;
      restore_flags_next = restore_flags_reg;
      error_next         = error_reg;
      if (do_push && !do_pop) begin
         count_next = count_reg + CW'(1);
      end else if (do_pop && !do_push) begin
         count_next = count_reg - CW'(1);
      end
      if (do_pop) begin
         restore_flags_next = ctx_mem[top_idx];
      end
      if (err_set) begin
         error_next = 1'b1;
      end else if (clear_error) begin
         error_next = 1'b0;
      end
   end

   // Storage has no reset: entries above count are meaningless, so clearing
   // count on reset discards the contents.
   always_ff @(posedge clock) begin
      if (do_push) begin
         ctx_mem[wr_idx] <= live_flags;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_reg         <= '0;
         restore_valid_reg <= 1'b0;
         restore_flags_reg <= '0;
         error_reg         <= 1'b0;
      end else begin
         count_reg         <= count_next;
         restore_valid_reg <= do_pop;
         restore_flags_reg <= restore_flags_next;
         error_reg         <= error_next;
      end
   end

   assign restore_valid = restore_valid_reg;
   assign restore_flags = restore_flags_reg;
   assign stack_empty   = empty;
   assign stack_full    = full;
   assign stack_error   = error_reg;
`else
   // No context storage: stack controls are ignored, outputs sit idle.
   logic unused_stack_inputs;
   assign unused_stack_inputs = ^{push, pop, clear_error};

   assign restore_valid = 1'b0;
   assign restore_flags = 5'd0;
   assign stack_empty   = 1'b1;
   assign stack_full    = 1'b0;
   assign stack_error   = 1'b0;
`endif

endmodule

// File: tb/tb_branch_condition_unit.sv
module tb_branch_condition_unit;

   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag;
   logic       req_valid;
   logic [3:0] req_cond;
   logic       req_ready;
   logic       res_valid;
   logic       res_taken;
   logic       res_ready;
   logic       push;
   logic       pop;
   logic       restore_valid;
   logic [4:0] restore_flags;
   logic       stack_empty;
   logic       stack_full;
   logic       stack_error;
   logic       clear_error;

   int tests_run    = 0;
   int tests_failed = 0;

   // Scoreboard of expected res_taken values, in acceptance order.
   logic exp_q[$];

   typedef struct {
      logic [4:0] flags;   // {N,Z,C,V,M}
      logic [3:0] cond;
      logic       exp;
   } vec_t;

   vec_t vecs[24];

   branch_condition_unit #(.DEPTH(DEPTH)) dut (
      .clock         (clock),
      .reset         (reset),
      .negative_flag (negative_flag),
      .zero_flag     (zero_flag),
      .carry_flag    (carry_flag),
      .overflow_flag (overflow_flag),
      .mode_flag     (mode_flag),
      .req_valid     (req_valid),
      .req_cond      (req_cond),
      .req_ready     (req_ready),
      .res_valid     (res_valid),
      .res_taken     (res_taken),
      .res_ready     (res_ready),
      .push          (push),
      .pop           (pop),
      .restore_valid (restore_valid),
      .restore_flags (restore_flags),
      .stack_empty   (stack_empty),
      .stack_full    (stack_full),
      .stack_error   (stack_error),
      .clear_error   (clear_error)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic set_flags(input logic [4:0] f);
      negative_flag = f[4];
      zero_flag     = f[3];
      carry_flag    = f[2];
      overflow_flag = f[1];
      mode_flag     = f[0];
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // Result monitor: a held result with res_ready high is consumed at the
   // coming edge, so each result is compared exactly once.
   always @(negedge clock) begin
      if (reset && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_result: got taken=%0b, expected no result", res_taken);
         end else begin
            logic e;
            e = exp_q.pop_front();
            $display("[TB] result consumed taken=%0b expected=%0b", res_taken, e);
            check("res_taken", {31'd0, res_taken}, {31'd0, e});
         end
      end
   end

   task automatic stack_op(input logic p, input logic q, input logic clr, input logic [4:0] f);
      set_flags(f);
      push        = p;
      pop         = q;
      clear_error = clr;
      next_cycle();
      push        = 1'b0;
      pop         = 1'b0;
      clear_error = 1'b0;
      $display("[TB] stack push=%0b pop=%0b clr=%0b flags=%02h -> rv=%0b rf=%02h empty=%0b full=%0b err=%0b",
               p, q, clr, f, restore_valid, restore_flags, stack_empty, stack_full, stack_error);
   endtask

   task automatic check_stack(input string name, input logic rv, input logic [4:0] rf,
                              input logic emp, input logic ful, input logic err);
      check({name, "_restore_valid"}, {31'd0, restore_valid}, {31'd0, rv});
      check({name, "_restore_flags"}, {27'd0, restore_flags}, {27'd0, rf});
      check({name, "_stack_empty"},   {31'd0, stack_empty},   {31'd0, emp});
      check({name, "_stack_full"},    {31'd0, stack_full},    {31'd0, ful});
      check({name, "_stack_error"},   {31'd0, stack_error},   {31'd0, err});
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_res_valid"}, {31'd0, res_valid}, 32'd0);
      check({name, "_res_taken"}, {31'd0, res_taken}, 32'd0);
      check({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      check_stack(name, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int wait_cycles;

      // Vector table: flags {N,Z,C,V,M}, condition, expected outcome.
      vecs[0]  = '{5'b01000, 4'd0,  1'b1};   // Z=1: EQ
      vecs[1]  = '{5'b01000, 4'd1,  1'b0};   // NE
      vecs[2]  = '{5'b01000, 4'd8,  1'b0};   // HI
      vecs[3]  = '{5'b01000, 4'd9,  1'b1};   // LS
      vecs[4]  = '{5'b01000, 4'd14, 1'b1};   // AL
      vecs[5]  = '{5'b10000, 4'd10, 1'b0};   // N=1 V=0: GE
      vecs[6]  = '{5'b10000, 4'd11, 1'b1};   // LT
      vecs[7]  = '{5'b10000, 4'd13, 1'b1};   // LE
      vecs[8]  = '{5'b10000, 4'd12, 1'b0};   // GT
      vecs[9]  = '{5'b00001, 4'd15, 1'b1};   // M=1: SV
      vecs[10] = '{5'b00000, 4'd15, 1'b0};   // M=0: SV
      vecs[11] = '{5'b00100, 4'd8,  1'b1};   // C=1 Z=0: HI
      vecs[12] = '{5'b00100, 4'd2,  1'b1};   // CS
      vecs[13] = '{5'b00100, 4'd3,  1'b0};   // CC
      vecs[14] = '{5'b00100, 4'd9,  1'b0};   // LS
      vecs[15] = '{5'b10010, 4'd10, 1'b1};   // N=1 V=1: GE
      vecs[16] = '{5'b10010, 4'd11, 1'b0};   // LT
      vecs[17] = '{5'b10010, 4'd12, 1'b1};   // GT
      vecs[18] = '{5'b10010, 4'd6,  1'b1};   // VS
      vecs[19] = '{5'b10010, 4'd7,  1'b0};   // VC
      vecs[20] = '{5'b10010, 4'd4,  1'b1};   // MI
      vecs[21] = '{5'b10010, 4'd5,  1'b0};   // PL
      vecs[22] = '{5'b11010, 4'd12, 1'b0};   // Z=1 N=V: GT
      vecs[23] = '{5'b11010, 4'd13, 1'b1};   // LE

      set_flags(5'h00);
      req_valid   = 1'b0;
      req_cond    = 4'd0;
      res_ready   = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      clear_error = 1'b0;

      // Reset state.
      repeat (2) @(posedge clock);
      #1;
      check_reset_values("reset");
      @(negedge clock);
      reset = 1'b1;
      next_cycle();

      // Back-to-back table vectors, one accept per cycle.
      for (int i = 0; i < $size(vecs); i++) begin
         set_flags(vecs[i].flags);
         req_cond  = vecs[i].cond;
         req_valid = 1'b1;
         res_ready = 1'b1;
         @(negedge clock);
         check("req_ready_b2b", {31'd0, req_ready}, 32'd1);
         if (i > 0) check("res_valid_b2b", {31'd0, res_valid}, 32'd1);
         exp_q.push_back(vecs[i].exp);
         next_cycle();
      end
      req_valid = 1'b0;
      next_cycle();
      next_cycle();
      check("res_valid_idle", {31'd0, res_valid}, 32'd0);

      // Backpressure: result must hold while flags change under it.
      res_ready = 1'b0;
      set_flags(5'b01000);
      req_cond  = 4'd0;
      req_valid = 1'b1;
      @(negedge clock);
      check("bp_accept_ready", {31'd0, req_ready}, 32'd1);
      exp_q.push_back(1'b1);
      next_cycle();
      set_flags(5'b00000);
      for (int s = 0; s < 3; s++) begin
         @(negedge clock);
         check("bp_res_valid", {31'd0, res_valid}, 32'd1);
         check("bp_res_taken", {31'd0, res_taken}, 32'd1);
         check("bp_req_ready", {31'd0, req_ready}, 32'd0);
         next_cycle();
      end
      // Release: the pending request is accepted in the res_ready cycle, with
      // Z=0 now sampled, so EQ is not taken.
      res_ready = 1'b1;
      @(negedge clock);
      check("bp_release_ready", {31'd0, req_ready}, 32'd1);
      exp_q.push_back(1'b0);
      next_cycle();
      req_valid = 1'b0;
      next_cycle();

      wait_cycles = 0;
      while (exp_q.size() != 0 && wait_cycles < 20) begin
         next_cycle();
         wait_cycles++;
      end
      check("queue_drained", exp_q.size(), 32'd0);

`ifdef BCU_CTX_STACK_EN
      // Fill to DEPTH, then overflow.
      stack_op(1'b1, 1'b0, 1'b0, 5'h01);
      check_stack("push1", 1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
      stack_op(1'b1, 1'b0, 1'b0, 5'h02);
      stack_op(1'b1, 1'b0, 1'b0, 5'h04);
      stack_op(1'b1, 1'b0, 1'b0, 5'h08);
      check_stack("push4", 1'b0, 5'h00, 1'b0, 1'b1, 1'b0);
      stack_op(1'b1, 1'b0, 1'b0, 5'h10);
      check_stack("overflow", 1'b0, 5'h00, 1'b0, 1'b1, 1'b1);
      // Four pops restore in reverse order.
      stack_op(1'b0, 1'b1, 1'b0, 5'h00);
      check_stack("pop1", 1'b1, 5'h08, 1'b0, 1'b0, 1'b1);
      stack_op(1'b0, 1'b1, 1'b0, 5'h00);
      check_stack("pop2", 1'b1, 5'h04, 1'b0, 1'b0, 1'b1);
      stack_op(1'b0, 1'b1, 1'b0, 5'h00);
      check_stack("pop3", 1'b1, 5'h02, 1'b0, 1'b0, 1'b1);
      stack_op(1'b0, 1'b1, 1'b0, 5'h00);
      check_stack("pop4", 1'b1, 5'h01, 1'b1, 1'b0, 1'b1);
      stack_op(1'b0, 1'b0, 1'b0, 5'h00);
      check_stack("idle_hold", 1'b0, 5'h01, 1'b1, 1'b0, 1'b1);
      stack_op(1'b0, 1'b0, 1'b1, 5'h00);
      check_stack("clear", 1'b0, 5'h01, 1'b1, 1'b0, 1'b0);
      // Underflow, and error winning over a simultaneous clear.
      stack_op(1'b0, 1'b1, 1'b0, 5'h00);
      check_stack("underflow", 1'b0, 5'h01, 1'b1, 1'b0, 1'b1);
      stack_op(1'b0, 1'b0, 1'b1, 5'h00);
      check_stack("clear2", 1'b0, 5'h01, 1'b1, 1'b0, 1'b0);
      stack_op(1'b0, 1'b1, 1'b1, 5'h00);
      check_stack("clr_vs_err", 1'b0, 5'h01, 1'b1, 1'b0, 1'b1);
      stack_op(1'b0, 1'b0, 1'b1, 5'h00);
      // Push+pop on a non-empty stack swaps the top entry.
      stack_op(1'b1, 1'b0, 1'b0, 5'h03);
      stack_op(1'b1, 1'b1, 1'b0, 5'h1C);
      check_stack("swap", 1'b1, 5'h03, 1'b0, 1'b0, 1'b0);
      stack_op(1'b0, 1'b1, 1'b0, 5'h00);
      check_stack("swap_pop", 1'b1, 5'h1C, 1'b1, 1'b0, 1'b0);
      // Push+pop on an empty stack: push executes, pop flagged.
      stack_op(1'b1, 1'b1, 1'b0, 5'h15);
      check_stack("pp_empty", 1'b0, 5'h1C, 1'b0, 1'b0, 1'b1);
      stack_op(1'b0, 1'b1, 1'b1, 5'h00);
      check_stack("pp_empty_pop", 1'b1, 5'h15, 1'b1, 1'b0, 1'b0);
`else
      stack_op(1'b1, 1'b0, 1'b0, 5'h1F);
      check_stack("nostack_push", 1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
      stack_op(1'b0, 1'b1, 1'b0, 5'h00);
      check_stack("nostack_pop", 1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
      stack_op(1'b0, 1'b1, 1'b0, 5'h00);
      check_stack("nostack_pop2", 1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
`endif

      // Asynchronous reset mid-operation: held result and two stacked entries.
      res_ready = 1'b0;
      set_flags(5'h00);
      req_cond  = 4'd14;
      req_valid = 1'b1;
      next_cycle();
      req_valid = 1'b0;
      stack_op(1'b1, 1'b0, 1'b0, 5'h0A);
      stack_op(1'b1, 1'b1, 1'b0, 5'h05);
      stack_op(1'b1, 1'b0, 1'b0, 5'h06);
      check("pre_reset_res_valid", {31'd0, res_valid}, 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check_reset_values("async_reset");
      exp_q.delete();
      @(negedge clock);
      reset = 1'b1;
      next_cycle();
      check_reset_values("post_reset");

      // Condition path still operational after reset.
      res_ready = 1'b1;
      set_flags(5'b01000);
      req_cond  = 4'd1;
      req_valid = 1'b1;
      @(negedge clock);
      check("post_reset_ready", {31'd0, req_ready}, 32'd1);
      exp_q.push_back(1'b0);
      next_cycle();
      req_valid = 1'b0;
      next_cycle();
      next_cycle();
      check("final_queue_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/branch_condition_unit.md
# branch_condition_unit

Consumer side of the processor status flags. Samples the N/Z/C/V/M flags driven by the status register, evaluates 4-bit branch condition codes behind a valid/ready handshake with one registered result stage, and keeps a LIFO of saved flag contexts so software-interrupt entry/return can snapshot and restore the flags. Sits between the decode stage (condition requests, push/pop commands) and the status register's restore path.

## Interface
- `DEPTH`, 4: number of flag-context entries in the LIFO (2..16).
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `negative_flag`, `zero_flag`, `carry_flag`, `overflow_flag`, `mode_flag`  in  1 each  live status flags.
- `req_valid`  in  1  condition request present.
- `req_cond`  in  4  condition code.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `res_valid`  out  1  result held.
- `res_taken`  out  1  condition outcome.
- `res_ready`  in  1  downstream consumes result.
- `push`  in  1  save current 5 flags onto the LIFO.
- `pop`  in  1  restore top entry.
- `restore_valid`  out  1  one-cycle pulse, restored flags on `restore_flags`.
- `restore_flags`  out  5  {N,Z,C,V,M}.
- `stack_empty`, `stack_full`  out  1 each  LIFO status.
- `stack_error`  out  1  sticky; overflow or underflow seen.
- `clear_error`  in  1  synchronous clear of `stack_error`.

## Operation
- Condition decode on sampled flags: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 SV M (taken only in mode 1).
- Flags sampled in the acceptance cycle, not at consume time.
- Result FSM: EMPTY, FULL. `req_ready = !res_valid | res_ready`. EMPTY + accept -> FULL. FULL + `res_ready` and no accept -> EMPTY. FULL + `res_ready` + accept -> FULL with new result (back-to-back, 1 per cycle). FULL without `res_ready`: `res_taken` stable.
- LIFO: count 0..DEPTH. Push (not full): store flags at [count], count+1. Pop (not empty): output entry [count-1], count-1.
- Push+pop same cycle, not empty: `restore_flags` = old top, current flags overwrite the same slot, count unchanged. Push+pop when empty: pop ignored (underflow error), push executes.
- Push when full (without pop): dropped, `stack_error` set. Pop when empty: no `restore_valid`, `stack_error` set.
- `clear_error` in the same cycle as a new error: error wins (stays 1).
- `stack_empty = (count==0)`, `stack_full = (count==DEPTH)`.

## Timing
- Reset (async assert, sync deassert externally): `res_valid`=0, `res_taken`=0, `req_ready`=1, `restore_valid`=0, `restore_flags`=0, count=0 (`stack_empty`=1, `stack_full`=0), `stack_error`=0. Pending result and LIFO contents are discarded on reset mid-operation.
- Request latency: accept at edge k -> `res_valid`/`res_taken` valid after edge k.
- Pop latency: pop sampled at edge k -> `restore_valid`=1 and `restore_flags` valid for exactly the cycle after edge k. `restore_flags` holds its value otherwise.
- Flag changes in the same cycle as a push are captured as presented before the edge.

## Configuration
- `BCU_CTX_STACK_EN` defined: LIFO, push/pop, `stack_*` and restore outputs as above.
- Not defined: no LIFO storage; `push`/`pop`/`clear_error` ignored; `restore_valid`=0, `restore_flags`=0, `stack_empty`=1, `stack_full`=0, `stack_error`=0 constant. Condition path unchanged.

## Test plan
- Flags Z=1, others 0; requests 0,1,8,9,14 back-to-back with `res_ready`=1 -> `res_taken` 1,0,0,1,1 on consecutive cycles, `req_ready` stays 1.
- N=1, V=0: cond 10 -> 0, cond 11 -> 1, cond 13 -> 1; M=1 cond 15 -> 1, M=0 cond 15 -> 0.
- Backpressure: accept cond 0 with Z=1, `res_ready`=0 for 3 cycles, flip Z=0 -> `res_taken` stays 1, `req_ready`=0; new request accepted in the `res_ready` cycle.
- DEPTH=4: push flags 5'h01,5'h02,5'h04,5'h08 -> `stack_full`=1; 5th push -> `stack_error`=1, count 4; four pops -> `restore_flags` 08,04,02,01 pulses, then `stack_empty`=1.
- Empty pop -> no `restore_valid`, `stack_error`=1; `clear_error` -> 0. Push+pop with top=5'h03, flags 5'h1C -> restore 03, next pop restores 1C.
- Assert `reset` low while `res_valid`=1 and count=2 -> all outputs at reset values immediately, without waiting for a clock edge.
